// File: rtl/drink_dispenser.sv
// Dispense-mechanism controller: runs the motor until a can drops, answers with a fin pulse, tracks stock.
// Optional jam timeout enabled by defining DRINK_JAM_TIMEOUT_EN.
module drink_dispenser #(
    parameter int unsigned MOTOR_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned FIN_HOLD       = 8,
    parameter int unsigned STOCK_W        = 4,
    parameter int unsigned STOCK_INIT     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               drink_contral,
    input  logic               drop_sensor,
    input  logic               refill,
    output logic               motor_on,
    output logic               drink_output_fin,
    output logic               empty,
    output logic               jam,
    output logic [STOCK_W-1:0] stock
);

    localparam int unsigned RUN_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LEN_W = RUN_W + 1;
    localparam int unsigned FIN_W = (FIN_HOLD > 1) ? $clog2(FIN_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_WAIT_REL,
        S_JAM
    } state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [FIN_W-1:0]   fin_cnt_q, fin_cnt_d;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               drop_seen_q, drop_seen_d;
    logic               motor_q, motor_d;
    logic               fin_q, fin_d;
    logic               empty_q, empty_d;
    logic               jam_q, jam_d;
    logic               sync1_q, sync2_q, sync3_q;

    logic               drop_evt_c;
    logic [LEN_W-1:0]   run_len_c;
    logic               min_done_c;
    logic               timeout_c;

    // Two-flop synchronizer plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= drop_sensor;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign drop_evt_c = sync2_q & ~sync3_q;

    // Number of RUN cycles including the current one
    assign run_len_c  = LEN_W'(run_cnt_q) + LEN_W'(1);
    assign min_done_c = (run_len_c >= LEN_W'(MOTOR_CYCLES));

`ifdef DRINK_JAM_TIMEOUT_EN
    assign timeout_c  = (run_len_c >= LEN_W'(TIMEOUT_CYCLES));
`else
    assign timeout_c  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            run_cnt_q   <= '0;
            fin_cnt_q   <= '0;
            stock_q     <= STOCK_W'(STOCK_INIT);
            drop_seen_q <= 1'b0;
            motor_q     <= 1'b0;
            fin_q       <= 1'b0;
            empty_q     <= (STOCK_INIT == 0);
            jam_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            fin_cnt_q   <= fin_cnt_d;
            stock_q     <= stock_d;
            drop_seen_q <= drop_seen_d;
            motor_q     <= motor_d;
            fin_q       <= fin_d;
            empty_q     <= empty_d;
            jam_q       <= jam_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        fin_cnt_d   = fin_cnt_q;
        stock_d     = stock_q;
        drop_seen_d = drop_seen_q;

        case (state_q)
            S_IDLE: begin
                if (refill) begin
                    stock_d = STOCK_W'(STOCK_INIT);
                end else if (drink_contral && (stock_q != '0)) begin
                    state_d     = S_RUN;
                    run_cnt_d   = '0;
                    drop_seen_d = 1'b0;
                end
            end

            S_RUN: begin
                if (drop_evt_c) begin
                    drop_seen_d = 1'b1;
                end
`ifdef DRINK_JAM_TIMEOUT_EN
                run_cnt_d = RUN_W'(run_len_c);
`else
                // Only the minimum-time comparison matters, so stop counting there
                if (run_len_c <= LEN_W'(MOTOR_CYCLES)) begin
                    run_cnt_d = RUN_W'(run_len_c);
                end
`endif
                // A drop landing in the timeout cycle beats the jam
                if ((drop_seen_q && min_done_c) || (timeout_c && drop_evt_c)) begin
                    state_d   = S_FIN;
                    fin_cnt_d = '0;
                    stock_d   = stock_q - STOCK_W'(1);
                end else if (timeout_c) begin
                    state_d = S_JAM;
                end
            end

            S_FIN: begin
                if (fin_cnt_q == FIN_W'(FIN_HOLD - 1)) begin
                    state_d = S_WAIT_REL;
                end else begin
                    fin_cnt_d = fin_cnt_q + FIN_W'(1);
                end
            end

            S_WAIT_REL: begin
                if (!drink_contral) begin
                    state_d = S_IDLE;
                end
            end

            S_JAM: begin
                if (refill) begin
                    state_d = S_IDLE;
                    stock_d = STOCK_W'(STOCK_INIT);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies
        motor_d = (state_d == S_RUN);
        fin_d   = (state_d == S_FIN);
        empty_d = (stock_d == '0);
`ifdef DRINK_JAM_TIMEOUT_EN
        jam_d   = (state_d == S_JAM);
`else
        jam_d   = 1'b0;
`endif
    end

    assign motor_on         = motor_q;
    assign drink_output_fin = fin_q;
    assign empty            = empty_q;
    assign jam              = jam_q;
    assign stock            = stock_q;

endmodule

// File: tb/tb_drink_dispenser.sv
// Randomized bench for drink_dispenser against a transaction-level model of dispense timing and stock.
// Jam scenarios follow DRINK_JAM_TIMEOUT_EN when it is defined for the build.
module tb_drink_dispenser;

    localparam int unsigned MOTOR_CYCLES   = 16;
    localparam int unsigned TIMEOUT_CYCLES = 255;
    localparam int unsigned FIN_HOLD       = 8;
    localparam int unsigned STOCK_W        = 4;
    localparam int unsigned STOCK_INIT     = 10;

    logic               clk;
    logic               rst;
    logic               drink_contral;
    logic               drop_sensor;
    logic               refill;
    logic               motor_on;
    logic               drink_output_fin;
    logic               empty;
    logic               jam;
    logic [STOCK_W-1:0] stock;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned exp_stock;

    drink_dispenser #(
        .MOTOR_CYCLES  (MOTOR_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIN_HOLD      (FIN_HOLD),
        .STOCK_W       (STOCK_W),
        .STOCK_INIT    (STOCK_INIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .drink_contral   (drink_contral),
        .drop_sensor     (drop_sensor),
        .refill          (refill),
        .motor_on        (motor_on),
        .drink_output_fin(drink_output_fin),
        .empty           (empty),
        .jam             (jam),
        .stock           (stock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dispense: sensor rises during motor cycle drop_at (1-based), request held for hold extra cycles
    task automatic dispense(input int unsigned drop_at, input bit refill_in_run, input int unsigned hold);
        int unsigned k;
        int unsigned exp_dur;
        int unsigned fin_w;
        int unsigned extra_on;
        bit          exp_jam;

        exp_jam = 1'b0;
        exp_dur = (drop_at + 3 > MOTOR_CYCLES) ? drop_at + 3 : MOTOR_CYCLES;
`ifdef DRINK_JAM_TIMEOUT_EN
        if (drop_at + 2 > TIMEOUT_CYCLES) begin
            exp_jam = 1'b1;
            exp_dur = TIMEOUT_CYCLES;
        end else if (drop_at + 2 == TIMEOUT_CYCLES) begin
            exp_dur = TIMEOUT_CYCLES;
        end
`endif

        drink_contral = 1'b1;
        tick();
        check("req_to_motor", motor_on, 1);
        k = 1;
        while (motor_on && k < 1000) begin
            if (k == drop_at)          drop_sensor = 1'b1;
            else if (k == drop_at + 2) drop_sensor = 1'b0;
            refill = refill_in_run && (k == 3);
            tick();
            if (motor_on) k++;
        end
        drop_sensor = 1'b0;
        refill      = 1'b0;
        check("motor_cycles", k, exp_dur);

        if (exp_jam) begin
            check("jam_set", jam, 1);
            check("jam_no_fin", drink_output_fin, 0);
            check("jam_stock", stock, exp_stock);
            drink_contral = 1'b0;
            repeat (3) tick();
            check("jam_sticky", jam, 1);
            refill = 1'b1;
            tick();
            refill = 1'b0;
            exp_stock = STOCK_INIT;
            check("jam_clear", jam, 0);
            check("jam_refill_stock", stock, exp_stock);
            tick();
            check("jam_idle", motor_on, 0);
            return;
        end

        check("fin_rise", drink_output_fin, 1);
        check("jam_low", jam, 0);
        exp_stock = exp_stock - 1;
        check("stock_dec", stock, exp_stock);
        check("empty_flag", empty, (exp_stock == 0) ? 1 : 0);

        fin_w = 1;
        while (drink_output_fin && fin_w <= FIN_HOLD + 4) begin
            tick();
            if (drink_output_fin) fin_w++;
        end
        check("fin_width", fin_w, FIN_HOLD);

        extra_on = 0;
        repeat (hold) begin
            tick();
            if (motor_on || drink_output_fin) extra_on++;
        end
        check("no_redispense", extra_on, 0);
        drink_contral = 1'b0;
        tick();
        repeat ($urandom_range(1, 4)) tick();
    endtask

    // Request with no stock: nothing moves until refill, then the held request dispenses
    task automatic empty_then_refill();
        int unsigned moved;
        moved = 0;
        drink_contral = 1'b1;
        repeat (20) begin
            tick();
            if (motor_on || drink_output_fin) moved++;
        end
        check("empty_no_motor", moved, 0);
        check("empty_high", empty, 1);
        check("empty_stock", stock, 0);
        refill = 1'b1;
        tick();
        refill = 1'b0;
        exp_stock = STOCK_INIT;
        check("refill_stock", stock, exp_stock);
        check("refill_empty", empty, 0);
        check("refill_idle", motor_on, 0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_stock     = STOCK_INIT;
        rst           = 1'b0;
        drink_contral = 1'b0;
        drop_sensor   = 1'b0;
        refill        = 1'b0;

        repeat (3) tick();
        check("rst_motor", motor_on, 0);
        check("rst_fin", drink_output_fin, 0);
        check("rst_jam", jam, 0);
        check("rst_stock", stock, STOCK_INIT);
        check("rst_empty", empty, 0);
        rst = 1'b1;
        repeat (2) tick();

        // Early drop, late drop, then randomized dispenses running the stock dry and back
        for (int i = 0; i < 12; i++) begin
            int unsigned d;
            if (exp_stock == 0) empty_then_refill();
            if (i == 0)      d = 5;
            else if (i == 1) d = 30;
            else             d = $urandom_range(1, 40);
            dispense(d, (i > 1) && ($urandom_range(0, 1) == 1), $urandom_range(1, 6));
        end

        // Drop right at the timeout boundary, then no drop within the timeout
        dispense(TIMEOUT_CYCLES - 2, 1'b0, 2);
        dispense(300, 1'b0, 2);

        // Asynchronous reset seven cycles into RUN
        drink_contral = 1'b1;
        tick();
        check("rr_motor_start", motor_on, 1);
        repeat (6) tick();
        #2 rst = 1'b0;
        #1;
        check("rr_motor_off", motor_on, 0);
        check("rr_fin_off", drink_output_fin, 0);
        check("rr_stock", stock, STOCK_INIT);
        check("rr_empty", empty, 0);
        exp_stock = STOCK_INIT;
        drink_contral = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) tick();
        check("rr_idle", motor_on, 0);
        dispense(2, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
